// File: rtl/image_line_source.sv
// Frame-memory to pixel-stream source: primes a line buffer, then sends one line (image or zero pad) per consumer interrupt.
// Optional define IMAGE_LINE_SOURCE_TLAST_EN adds o_data_last, marking the last pixel of every line.
module image_line_source #(
  parameter int IMG_WIDTH   = 512,
  parameter int IMG_HEIGHT  = 512,
  parameter int PRIME_LINES = 4,
  parameter int PAD_LINES   = 2,
  parameter int ADDR_W      = 18
) (
  input  logic              axi_clk,
  input  logic              axi_reset_n,
  input  logic              i_start,
  output logic              o_busy,
  output logic              o_done,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_en,
  input  logic [7:0]        i_mem_data,
  output logic [7:0]        o_data,
  output logic              o_data_valid,
`ifdef IMAGE_LINE_SOURCE_TLAST_EN
  output logic              o_data_last,
`endif
  input  logic              i_data_ready,
  input  logic              i_intr
);

  localparam int PIX_W  = $clog2(IMG_WIDTH + 1);
  localparam int LINE_W = $clog2(IMG_HEIGHT + 1);
  localparam int PAD_W  = $clog2(PAD_LINES + 2);
  localparam logic [PIX_W-1:0]  LAST_PIX   = PIX_W'(IMG_WIDTH - 1);
  localparam logic [LINE_W-1:0] LAST_PRIME = LINE_W'(PRIME_LINES - 1);
  localparam logic [LINE_W-1:0] LAST_LINE  = LINE_W'(IMG_HEIGHT - 1);
  localparam logic [PAD_W-1:0]  NUM_PAD    = PAD_W'(PAD_LINES);
  localparam logic [PAD_W-1:0]  LAST_PAD   = PAD_W'(PAD_LINES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_PRIME, S_WAIT_LINE, S_LINE, S_WAIT_PAD, S_PAD, S_DRAIN
  } state_t;

  state_t              r_state, w_state_next, w_after_img;
  logic [ADDR_W-1:0]   r_addr;
  logic [PIX_W-1:0]    r_pix_cnt;
  logic [LINE_W-1:0]   r_line_cnt;
  logic [PAD_W-1:0]    r_pad_cnt;
  logic                r_intr_d, r_pending, r_done;
  logic                r_rd_vld, r_rd_pad;
  logic [7:0]          r_fifo_data [2];
  logic                r_wr_ptr, r_rd_ptr;
  logic [1:0]          r_count;
  logic [2:0]          w_occ;
  logic                w_pop, w_sending, w_issue, w_line_end, w_edge, w_start;
  logic                w_consume, w_drained;

  assign w_pop      = o_data_valid && i_data_ready;
  assign w_sending  = (r_state == S_PRIME) || (r_state == S_LINE) || (r_state == S_PAD);
  // Occupancy after this cycle's pop plus the read already in flight; keeps ready=1 at one pixel per cycle.
  assign w_occ      = {1'b0, r_count} + {2'b00, r_rd_vld} - {2'b00, w_pop};
  assign w_issue    = w_sending && (w_occ < 3'd2);
  assign w_line_end = w_issue && (r_pix_cnt == LAST_PIX);
  assign w_edge     = i_intr && !r_intr_d;
  assign w_start    = (r_state == S_IDLE) && i_start;

  assign o_busy       = (r_state != S_IDLE);
  assign o_done       = r_done;
  assign o_mem_addr   = r_addr;
  assign o_mem_en     = w_issue && (r_state != S_PAD);
  assign o_data       = r_fifo_data[r_rd_ptr];
  assign o_data_valid = (r_count != 2'd0);

  always_comb begin
    w_state_next = r_state;
    w_consume    = 1'b0;
    w_drained    = 1'b0;
    w_after_img  = (r_line_cnt != LAST_LINE) ? S_WAIT_LINE :
                   ((PAD_LINES > 0) ? S_WAIT_PAD : S_DRAIN);
    case (r_state)
      S_IDLE:      if (i_start) w_state_next = S_PRIME;
      S_PRIME:     if (w_line_end && (r_line_cnt == LAST_PRIME)) w_state_next = w_after_img;
      S_LINE:      if (w_line_end) w_state_next = w_after_img;
      S_WAIT_LINE: if (r_pending) begin
        w_consume    = 1'b1;
        w_state_next = S_LINE;
      end
      S_WAIT_PAD: begin
        if (r_pad_cnt == NUM_PAD) begin
          w_state_next = S_DRAIN;
        end else if (r_pending) begin
          w_consume    = 1'b1;
          w_state_next = S_PAD;
        end
      end
      S_PAD:       if (w_line_end) w_state_next = (r_pad_cnt == LAST_PAD) ? S_DRAIN : S_WAIT_PAD;
      S_DRAIN: begin
        if (!r_rd_vld && ((r_count == 2'd0) || ((r_count == 2'd1) && w_pop))) begin
          w_drained    = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default:     w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) r_state <= S_IDLE;
    else              r_state <= w_state_next;
  end

  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      r_addr     <= '0;
      r_pix_cnt  <= '0;
      r_line_cnt <= '0;
      r_pad_cnt  <= '0;
      r_intr_d   <= 1'b0;
      r_pending  <= 1'b0;
      r_done     <= 1'b0;
      r_rd_vld   <= 1'b0;
      r_rd_pad   <= 1'b0;
    end else begin
      r_done   <= w_drained;
      r_intr_d <= i_intr;
      r_rd_vld <= w_issue;
      r_rd_pad <= (r_state == S_PAD);
      // A fresh edge wins over consumption so a late interrupt is never lost.
      if (w_start)        r_pending <= 1'b0;
      else if (w_edge)    r_pending <= 1'b1;
      else if (w_consume) r_pending <= 1'b0;
      if (w_start) begin
        r_addr     <= '0;
        r_pix_cnt  <= '0;
        r_line_cnt <= '0;
        r_pad_cnt  <= '0;
      end else if (w_issue) begin
        if (o_mem_en) r_addr <= r_addr + ADDR_W'(1);
        r_pix_cnt <= w_line_end ? '0 : r_pix_cnt + PIX_W'(1);
        if (w_line_end) begin
          if (r_state == S_PAD) r_pad_cnt  <= r_pad_cnt + PAD_W'(1);
          else                  r_line_cnt <= r_line_cnt + LINE_W'(1);
        end
      end
    end
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
      always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n)                         r_fifo_data[gi] <= '0;
        else if (r_rd_vld && (r_wr_ptr == 1'(gi))) r_fifo_data[gi] <= r_rd_pad ? 8'd0 : i_mem_data;
      end
    end
  endgenerate

  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (r_rd_vld) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)    r_rd_ptr <= ~r_rd_ptr;
      r_count <= r_count + {1'b0, r_rd_vld} - {1'b0, w_pop};
    end
  end

`ifdef IMAGE_LINE_SOURCE_TLAST_EN
  logic r_rd_last;
  logic r_fifo_last [2];

  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) r_rd_last <= 1'b0;
    else              r_rd_last <= w_line_end;
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_last
      always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n)                         r_fifo_last[gi] <= 1'b0;
        else if (r_rd_vld && (r_wr_ptr == 1'(gi))) r_fifo_last[gi] <= r_rd_last;
      end
    end
  endgenerate

  assign o_data_last = r_fifo_last[r_rd_ptr];
`endif

endmodule

// File: tb/tb_image_line_source.sv
// Scoreboard bench for image_line_source: prime, full frame, early interrupt, reset abort, random backpressure.
module tb_image_line_source;
  localparam int W = 8, H = 6, P = 4, PD = 2, AW = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0, intr = 1'b0, ready = 1'b1;
  logic          busy, done, mem_en, dvalid;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_q = 8'd0, dout;
`ifdef IMAGE_LINE_SOURCE_TLAST_EN
  logic          dlast;
`endif

  image_line_source #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .PRIME_LINES(P), .PAD_LINES(PD), .ADDR_W(AW)) dut (
    .axi_clk(clk), .axi_reset_n(rst_n), .i_start(start), .o_busy(busy), .o_done(done),
    .o_mem_addr(mem_addr), .o_mem_en(mem_en), .i_mem_data(mem_q),
    .o_data(dout), .o_data_valid(dvalid),
`ifdef IMAGE_LINE_SOURCE_TLAST_EN
    .o_data_last(dlast),
`endif
    .i_data_ready(ready), .i_intr(intr));

  always #5 clk = ~clk;

  function automatic logic [7:0] pix(input int a);
    return 8'((a * 7 + 3) & 255);
  endfunction

  always @(posedge clk) if (mem_en) mem_q <= pix(int'(mem_addr));

  typedef struct { logic [7:0] d; logic l; } exp_t;
  exp_t q[$];

  int checks = 0, failures = 0;
  bit rand_mode = 1'b0;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor: scoreboard pop, stall stability, read-room and done timing.
  int cyc = 0, frame_xfers = 0, reads = 0, done_cnt = 0;
  int start_cyc = 0, first_cyc = 0, last_cyc = 0, done_cyc = 0;
  bit prev_stall = 1'b0;
  logic [7:0] prev_data = 8'd0;
  always @(negedge clk) begin
    exp_t e;
    int   pop;
    cyc++;
    if (!rst_n) begin
      q.delete();
      prev_stall = 1'b0;
    end else begin
      if (start && !busy) begin
        frame_xfers = 0; reads = 0; done_cnt = 0; start_cyc = cyc;
      end
      pop = (dvalid && ready) ? 1 : 0;
      if (mem_en) chk("mem_en_room", int'((reads - frame_xfers - pop) < 2), 1);
      if (prev_stall) begin
        chk("stall_valid", int'(dvalid), 1);
        chk("stall_data", int'(dout), int'(prev_data));
      end
      prev_stall = dvalid && !ready;
      prev_data  = dout;
      if (pop == 1) begin
        if (q.size() == 0) begin
          chk("sb_underflow", q.size(), 1);
        end else begin
          e = q.pop_front();
          $display("xfer %0d data=%0d exp=%0d", frame_xfers, dout, e.d);
          chk("pixel", int'(dout), int'(e.d));
`ifdef IMAGE_LINE_SOURCE_TLAST_EN
          chk("tlast", int'(dlast), int'(e.l));
`endif
        end
        if (frame_xfers == 0) first_cyc = cyc;
        last_cyc = cyc;
        frame_xfers++;
      end
      if (mem_en) reads++;
      if (done) begin done_cnt++; done_cyc = cyc; end
    end
  end

  task automatic push_line(input int line);
    exp_t e;
    for (int x = 0; x < W; x++) begin
      e.d = (line < H) ? pix(line * W + x) : 8'd0;
      e.l = (x == W - 1);
      q.push_back(e);
    end
  endtask

  task automatic pulse(ref logic sig);
    @(posedge clk); #1 sig = 1'b1;
    @(posedge clk); #1 sig = 1'b0;
  endtask

  task automatic wait_empty(input string tag, input int budget);
    int n = 0;
    while (q.size() != 0 && n < budget) begin @(posedge clk); n++; end
    @(negedge clk);
    chk(tag, q.size(), 0);
  endtask

  task automatic run_tail(input string tag);
    for (int l = P; l < H + PD; l++) begin
      repeat (2) @(posedge clk);
      push_line(l);
      pulse(intr);
      wait_empty({tag, "_line"}, 400);
    end
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk({tag, "_xfers"}, frame_xfers, (H + PD) * W);
    chk({tag, "_done_cnt"}, done_cnt, 1);
    chk({tag, "_done_gap"}, done_cyc - last_cyc, 1);
    chk({tag, "_busy_end"}, int'(busy), 0);
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_valid", int'(dvalid), 0);
    chk("rst_mem_en", int'(mem_en), 0);
    chk("rst_addr", int'(mem_addr), 0);
    chk("rst_data", int'(dout), 0);

    // Prime then full frame, ready held high.
    for (int l = 0; l < P; l++) push_line(l);
    pulse(start);
    wait_empty("prime_drain", 300);
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("prime_xfers", frame_xfers, P * W);
    chk("prime_latency", first_cyc - start_cyc, 3);
    chk("prime_contig", last_cyc - first_cyc, P * W - 1);
    chk("prime_busy", int'(busy), 1);
    chk("prime_idle_valid", int'(dvalid), 0);
    run_tail("full");

    // Two edges during PRIME collapse into one extra line.
    for (int l = 0; l <= P; l++) push_line(l);
    pulse(start);
    repeat (8) @(posedge clk);
    pulse(intr);
    repeat (8) @(posedge clk);
    pulse(intr);
    wait_empty("early_drain", 300);
    repeat (30) @(posedge clk);
    @(negedge clk);
    chk("early_xfers", frame_xfers, (P + 1) * W);
    chk("early_busy", int'(busy), 1);

    // Abort mid-LINE with reset.
    push_line(P + 1);
    pulse(intr);
    n = 0;
    while (frame_xfers < (P + 1) * W + 3 && n < 100) begin @(posedge clk); n++; end
    chk("reset_reach_line", int'(frame_xfers >= (P + 1) * W + 3), 1);
    @(posedge clk); #1 rst_n = 1'b0;
    #1;
    chk("abort_valid", int'(dvalid), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_mem_en", int'(mem_en), 0);
    chk("abort_addr", int'(mem_addr), 0);
    chk("abort_data", int'(dout), 0);
    chk("abort_done", int'(done), 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("abort_no_done", done_cnt, 0);

    // Random backpressure, same expected stream.
    rand_mode = 1'b1;
    for (int l = 0; l < P; l++) push_line(l);
    pulse(start);
    wait_empty("bp_prime", 800);
    run_tail("bp");
    rand_mode = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
